// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter.
// Counts synchronised RO rising edges over a fixed window of clk cycles, then
// hands the result to a UART transmitter as a framed byte stream:
// header, count bytes MSB first, XOR checksum of the count bytes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for enable; counters hold their last values
// GATE  | measurement window open, gate_cnt running, edges counted
// LATCH | window closed, count snapshotted, meas_done pulsed
// REQ   | start high, current frame byte on latch_count, wait tx_busy=1
// WAIT  | byte accepted, wait tx_busy=0, then next byte / next window
`timescale 1ns/1ps
module ro_freq_meter #(
  parameter int          GATE_CYCLES = 100_000,
  parameter int          COUNT_W     = 24,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ro_in,
  input  logic       enable,
  input  logic       tx_busy,
  output logic       start,
  output logic [7:0] latch_count,
  output logic       meas_done,
  output logic       overflow,
  output logic       busy
);

  localparam int NBYTES = COUNT_W / 8;
  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int IDX_W  = 3;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_LATCH,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ro_sync;
  logic                edge_p;
  logic [GATE_W-1:0]   gate_cnt;
  logic [COUNT_W-1:0]  edge_cnt;
  logic [COUNT_W-1:0]  snap;
  logic [IDX_W-1:0]    byte_idx;
  logic                start_gate;
  logic [7:0]          frame_byte;
  logic [7:0]          csum;

  // Three-stage synchroniser for the asynchronous RO signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ro_sync <= '0;
    else        ro_sync <= {ro_sync[1:0], ro_in};
  end

  assign edge_p = ro_sync[1] & ~ro_sync[2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and Moore outputs; start_gate marks every entry into GATE.
  always_comb begin
    state_d    = state_q;
    start_gate = 1'b0;
    start      = 1'b0;
    meas_done  = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_GATE;
          start_gate = 1'b1;
        end
      end
      S_GATE: begin
        if (!enable)                    state_d = S_IDLE;
        else if (gate_cnt == GATE_LAST) state_d = S_LATCH;
      end
      S_LATCH: begin
        meas_done = 1'b1;
        state_d   = S_REQ;
      end
      S_REQ: begin
        start = 1'b1;
        // tx_busy already high here is taken as acceptance of this byte.
        if (tx_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (byte_idx == IDX_LAST) begin
            if (enable) begin
              state_d    = S_GATE;
              start_gate = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window counter, saturating edge counter and overflow flag.
  // overflow flags an edge that arrived while the counter was already full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      overflow <= 1'b0;
    end else if (start_gate) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      overflow <= 1'b0;
    end else if (state_q == S_GATE) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (edge_p) begin
        if (&edge_cnt) overflow <= 1'b1;
        else           edge_cnt <= edge_cnt + COUNT_W'(1);
      end
    end
  end

  // Snapshot of the count and position within the outgoing frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      byte_idx <= '0;
    end else if (state_q == S_LATCH) begin
      snap     <= edge_cnt;
      byte_idx <= '0;
    end else if (state_q == S_WAIT && !tx_busy && byte_idx != IDX_LAST) begin
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  // Frame byte selection: header, count bytes MSB first, then checksum.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < NBYTES; i++) csum = csum ^ snap[8*i +: 8];
    frame_byte = HEADER;
    if (byte_idx == IDX_LAST) begin
      frame_byte = csum;
    end else begin
      for (int k = 1; k <= NBYTES; k++) begin
        if (byte_idx == IDX_W'(k)) frame_byte = snap[8*(NBYTES-k) +: 8];
      end
    end
  end

  // Byte only presented while requesting; snap and byte_idx are frozen in REQ.
  always_comb begin
    latch_count = 8'h00;
    if (state_q == S_REQ) latch_count = frame_byte;
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit and an 8-bit instance share clk,
// reset and ro_in; a UART model with a 20-clk baud tick serves each one.
`timescale 1ns/1ps
module tb_ro_freq_meter;

  logic              clk;
  logic              rst_n;
  logic              ro;
  logic [1:0]        en;
  logic [1:0]        tx_busy;
  logic [1:0]        start_o;
  logic [1:0][7:0]   lc_o;
  logic [1:0]        md_o;
  logic [1:0]        ovf_o;
  logic [1:0]        busy_o;

  int total = 0;
  int bad   = 0;
  int ro_period = 0;

  logic [7:0] rx_buf [2][256];
  int         rx_n    [2] = '{0, 0};
  int         md_cnt  [2] = '{0, 0};
  int         rise_cnt[2] = '{0, 0};
  int         bits    [2] = '{0, 0};
  logic       prev_start [2] = '{1'b0, 1'b0};
  logic [7:0] prev_lc    [2] = '{8'h00, 8'h00};
  logic       busy_rose  [2] = '{1'b0, 1'b0};
  int         baud = 0;
  int         hs_checks = 0;
  int         hs_err = 0;

  ro_freq_meter #(.GATE_CYCLES(1000), .COUNT_W(16), .HEADER(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .ro_in(ro), .enable(en[0]), .tx_busy(tx_busy[0]),
    .start(start_o[0]), .latch_count(lc_o[0]), .meas_done(md_o[0]),
    .overflow(ovf_o[0]), .busy(busy_o[0]));

  ro_freq_meter #(.GATE_CYCLES(1000), .COUNT_W(8), .HEADER(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .ro_in(ro), .enable(en[1]), .tx_busy(tx_busy[1]),
    .start(start_o[1]), .latch_count(lc_o[1]), .meas_done(md_o[1]),
    .overflow(ovf_o[1]), .busy(busy_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RO source: period in clk cycles, 0 = stuck low; edges offset from clk edges.
  initial begin
    ro = 1'b0;
    #3;
    forever begin
      if (ro_period == 0) begin
        ro = 1'b0;
        #10;
      end else begin
        ro = 1'b1;
        #(ro_period * 5);
        ro = 1'b0;
        #(ro_period * 5);
      end
    end
  end

  // Handshake monitors followed by the UART model, all on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (start_o[i] && !prev_start[i]) begin
        rise_cnt[i]++;
        hs_checks++;
        if (tx_busy[i] !== 1'b0) hs_err++;
      end
      if (start_o[i] && prev_start[i]) begin
        hs_checks++;
        if (lc_o[i] !== prev_lc[i]) hs_err++;
      end
      if (busy_rose[i]) begin
        hs_checks++;
        if (start_o[i] !== 1'b0) hs_err++;
      end
      if (md_o[i]) md_cnt[i]++;
      prev_start[i] = start_o[i];
      prev_lc[i]    = lc_o[i];
      busy_rose[i]  = 1'b0;
    end
    if (!rst_n) begin
      baud    = 0;
      tx_busy = 2'b00;
      bits    = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (baud == 19) begin
          if (tx_busy[i]) begin
            bits[i]--;
            if (bits[i] == 0) tx_busy[i] = 1'b0;
          end else if (start_o[i]) begin
            if (rx_n[i] < 256) rx_buf[i][rx_n[i]] = lc_o[i];
            rx_n[i]++;
            tx_busy[i]   = 1'b1;
            bits[i]      = 10;
            busy_rose[i] = 1'b1;
          end
        end
      end
      baud = (baud == 19) ? 0 : baud + 1;
    end
  end

  // Bounded wait for the next meas_done of instance i after count base.
  task automatic wait_md(input int i, input int base, output bit ok, output int cycles);
    cycles = 0;
    while (md_cnt[i] <= base && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    ok = (md_cnt[i] > base);
  endtask

  task automatic wait_idle(input int i, output bit ok);
    int n = 0;
    @(negedge clk);
    while (busy_o[i] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (busy_o[i] === 1'b0);
  endtask

  task automatic wait_rise(input int i, input int target, output bit ok);
    int n = 0;
    while (rise_cnt[i] < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (rise_cnt[i] >= target);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      total++; if (start_o[i] !== 1'b0) begin bad++; $display("FAIL rst_start[%0d] got=%b want=0", i, start_o[i]); end
      total++; if (lc_o[i] !== 8'h00) begin bad++; $display("FAIL rst_latch_count[%0d] got=%h want=00", i, lc_o[i]); end
      total++; if (md_o[i] !== 1'b0) begin bad++; $display("FAIL rst_meas_done[%0d] got=%b want=0", i, md_o[i]); end
      total++; if (ovf_o[i] !== 1'b0) begin bad++; $display("FAIL rst_overflow[%0d] got=%b want=0", i, ovf_o[i]); end
      total++; if (busy_o[i] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got=%b want=0", i, busy_o[i]); end
    end
  endtask

  task automatic test_count_100;
    int bmd, brx, cyc;
    bit ok;
    ro_period = 10;
    repeat (30) @(negedge clk);
    bmd = md_cnt[0]; brx = rx_n[0];
    en[0] = 1'b1;
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL c100_meas_done_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    total++; if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL c100_overflow got=%b want=0", ovf_o[0]); end
    en[0] = 1'b0;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL c100_idle_timeout got=%b want=0", busy_o[0]); end
    total++; if (rx_n[0] - brx !== 4) begin bad++; $display("FAIL c100_nbytes got=%0d want=4", rx_n[0] - brx); end
    total++; if (md_cnt[0] - bmd !== 1) begin bad++; $display("FAIL c100_md_count got=%0d want=1", md_cnt[0] - bmd); end
    total++; if (rx_buf[0][brx] !== 8'hA5) begin bad++; $display("FAIL c100_hdr got=%h want=a5", rx_buf[0][brx]); end
    total++; if (rx_buf[0][brx+1] !== 8'h00) begin bad++; $display("FAIL c100_msb got=%h want=00", rx_buf[0][brx+1]); end
    total++;
    if (rx_buf[0][brx+2] < 8'd99 || rx_buf[0][brx+2] > 8'd101) begin
      bad++; $display("FAIL c100_lsb got=%h want=64(+/-1)", rx_buf[0][brx+2]);
    end
    total++; if (rx_buf[0][brx+3] !== rx_buf[0][brx+2]) begin bad++; $display("FAIL c100_csum got=%h want=%h", rx_buf[0][brx+3], rx_buf[0][brx+2]); end
  endtask

  task automatic test_stuck_low;
    int bmd, brx, cyc;
    bit ok;
    ro_period = 0;
    repeat (30) @(negedge clk);
    bmd = md_cnt[0]; brx = rx_n[0];
    en[0] = 1'b1;
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL stuck_meas_done_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    total++; if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL stuck_overflow got=%b want=0", ovf_o[0]); end
    en[0] = 1'b0;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stuck_idle_timeout got=%b want=0", busy_o[0]); end
    total++; if (rx_n[0] - brx !== 4) begin bad++; $display("FAIL stuck_nbytes got=%0d want=4", rx_n[0] - brx); end
    total++;
    if ({rx_buf[0][brx], rx_buf[0][brx+1], rx_buf[0][brx+2], rx_buf[0][brx+3]} !== 32'hA5000000) begin
      bad++;
      $display("FAIL stuck_frame got=%h %h %h %h want=a5 00 00 00",
               rx_buf[0][brx], rx_buf[0][brx+1], rx_buf[0][brx+2], rx_buf[0][brx+3]);
    end
  endtask

  task automatic test_overflow;
    int bmd, brx, cyc;
    bit ok;
    ro_period = 2;
    repeat (30) @(negedge clk);
    bmd = md_cnt[1]; brx = rx_n[1];
    en[1] = 1'b1;
    wait_md(1, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL ovf_meas_done_timeout got=%0d want=%0d", md_cnt[1], bmd + 1); end
    total++; if (ovf_o[1] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", ovf_o[1]); end
    en[1] = 1'b0;
    wait_idle(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_idle_timeout got=%b want=0", busy_o[1]); end
    total++; if (rx_n[1] - brx !== 3) begin bad++; $display("FAIL ovf_nbytes got=%0d want=3", rx_n[1] - brx); end
    total++;
    if ({rx_buf[1][brx], rx_buf[1][brx+1], rx_buf[1][brx+2]} !== 24'hA5FFFF) begin
      bad++;
      $display("FAIL ovf_frame got=%h %h %h want=a5 ff ff", rx_buf[1][brx], rx_buf[1][brx+1], rx_buf[1][brx+2]);
    end
  endtask

  task automatic test_abort_gate;
    int bmd, brise;
    ro_period = 10;
    repeat (30) @(negedge clk);
    bmd = md_cnt[0]; brise = rise_cnt[0];
    en[0] = 1'b1;
    repeat (500) @(negedge clk);
    total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL abort_busy_in_gate got=%b want=1", busy_o[0]); end
    en[0] = 1'b0;
    @(negedge clk);
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL abort_busy_drop got=%b want=0", busy_o[0]); end
    repeat (1500) @(negedge clk);
    total++; if (md_cnt[0] !== bmd) begin bad++; $display("FAIL abort_no_meas_done got=%0d want=%0d", md_cnt[0], bmd); end
    total++; if (rise_cnt[0] !== brise) begin bad++; $display("FAIL abort_no_start got=%0d want=%0d", rise_cnt[0], brise); end
  endtask

  task automatic test_mid_frame_disable;
    int bmd, brx, brise, cyc;
    bit ok;
    bmd = md_cnt[0]; brx = rx_n[0]; brise = rise_cnt[0];
    en[0] = 1'b1;
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL mid_meas_done_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    wait_rise(0, brise + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_byte2_timeout got=%0d want=%0d", rise_cnt[0], brise + 2); end
    en[0] = 1'b0;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_idle_timeout got=%b want=0", busy_o[0]); end
    total++; if (rx_n[0] - brx !== 4) begin bad++; $display("FAIL mid_nbytes got=%0d want=4", rx_n[0] - brx); end
    total++; if (md_cnt[0] - bmd !== 1) begin bad++; $display("FAIL mid_md_count got=%0d want=1", md_cnt[0] - bmd); end
    total++;
    if (rx_buf[0][brx] !== 8'hA5 || rx_buf[0][brx+1] !== 8'h00 || rx_buf[0][brx+3] !== rx_buf[0][brx+2]
        || rx_buf[0][brx+2] < 8'd99 || rx_buf[0][brx+2] > 8'd101) begin
      bad++;
      $display("FAIL mid_frame got=%h %h %h %h want=a5 00 64 64",
               rx_buf[0][brx], rx_buf[0][brx+1], rx_buf[0][brx+2], rx_buf[0][brx+3]);
    end
  endtask

  task automatic test_back_to_back;
    int bmd, brx, cyc;
    bit ok;
    bmd = md_cnt[0]; brx = rx_n[0];
    en[0] = 1'b1;
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    wait_md(0, bmd + 1, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL b2b_second_timeout got=%0d want=%0d", md_cnt[0], bmd + 2); end
    en[0] = 1'b0;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle_timeout got=%b want=0", busy_o[0]); end
    total++; if (rx_n[0] - brx !== 8) begin bad++; $display("FAIL b2b_nbytes got=%0d want=8", rx_n[0] - brx); end
    for (int f = 0; f < 2; f++) begin
      total++;
      if (rx_buf[0][brx+4*f] !== 8'hA5 || rx_buf[0][brx+4*f+1] !== 8'h00
          || rx_buf[0][brx+4*f+2] < 8'd99 || rx_buf[0][brx+4*f+2] > 8'd101
          || rx_buf[0][brx+4*f+3] !== rx_buf[0][brx+4*f+2]) begin
        bad++;
        $display("FAIL b2b_frame%0d got=%h %h %h %h want=a5 00 64 64", f,
                 rx_buf[0][brx+4*f], rx_buf[0][brx+4*f+1], rx_buf[0][brx+4*f+2], rx_buf[0][brx+4*f+3]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int bmd, brx, brise, cyc;
    bit ok;
    bmd = md_cnt[0]; brise = rise_cnt[0];
    en[0] = 1'b1;
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL rmid_meas_done_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    wait_rise(0, brise + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_byte2_timeout got=%0d want=%0d", rise_cnt[0], brise + 2); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (start_o[0] !== 1'b0) begin bad++; $display("FAIL rmid_start got=%b want=0", start_o[0]); end
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy_o[0]); end
    total++; if (lc_o[0] !== 8'h00) begin bad++; $display("FAIL rmid_latch_count got=%h want=00", lc_o[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bmd = md_cnt[0]; brx = rx_n[0];
    wait_md(0, bmd, ok, cyc);
    total++; if (!ok) begin bad++; $display("FAIL rmid_regate_timeout got=%0d want=%0d", md_cnt[0], bmd + 1); end
    total++; if (cyc < 1000 || cyc > 1005) begin bad++; $display("FAIL rmid_full_gate got=%0d want=1000..1005", cyc); end
    en[0] = 1'b0;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_idle_timeout got=%b want=0", busy_o[0]); end
    total++; if (rx_n[0] - brx !== 4) begin bad++; $display("FAIL rmid_nbytes got=%0d want=4", rx_n[0] - brx); end
    total++;
    if (rx_buf[0][brx] !== 8'hA5 || rx_buf[0][brx+1] !== 8'h00 || rx_buf[0][brx+3] !== rx_buf[0][brx+2]
        || rx_buf[0][brx+2] < 8'd99 || rx_buf[0][brx+2] > 8'd101) begin
      bad++;
      $display("FAIL rmid_frame got=%h %h %h %h want=a5 00 64 64",
               rx_buf[0][brx], rx_buf[0][brx+1], rx_buf[0][brx+2], rx_buf[0][brx+3]);
    end
  endtask

  task automatic test_handshake;
    total++; if (hs_err !== 0) begin bad++; $display("FAIL handshake_violations got=%0d want=0", hs_err); end
    total++; if (hs_checks < 20) begin bad++; $display("FAIL handshake_coverage got=%0d want>=20", hs_checks); end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 2'b00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_count_100();
    test_stuck_low();
    test_overflow();
    test_abort_gate();
    test_mid_frame_disable();
    test_back_to_back();
    test_reset_mid_frame();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
